// File: rtl/mem_arbiter.sv
//============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction / data) arbiter in front of a single
//               memory port. Data has priority unless the instruction side
//               has waited through STARVE_LIMIT consecutive data grants.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   // instruction fetch port
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_done,
   output logic [DATA_WIDTH-1:0] i_rdata,
   // data port
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [2:0]            d_size,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_done,
   output logic [DATA_WIDTH-1:0] d_rdata,
   // memory port
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [2:0]            mem_size,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic                  busy
);

   localparam logic [3:0] c_LIMIT     = STARVE_LIMIT[3:0];
   localparam logic [2:0] c_WORD_SIZE = 3'b010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t     r_state;
   logic       r_owner_d;   // 1 = data port owns the current transaction
   logic [3:0] r_starve;    // consecutive data grants taken while a fetch waited

   logic w_any_req;
   logic w_grant_d;

   // Data wins unless the fetch side has been starved up to the limit
   assign w_any_req = i_req | d_req;
   assign w_grant_d = d_req & ~(i_req & (r_starve == c_LIMIT));

   // Busy reflects any non-idle state
   assign busy = (r_state != IDLE);

   // Arbitration FSM with registered memory-side and completion outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_owner_d   <= 1'b0;
         r_starve    <= 4'd0;
         i_done      <= 1'b0;
         i_rdata     <= '0;
         d_done      <= 1'b0;
         d_rdata     <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_size    <= 3'b000;
         mem_wdata   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_state <= ACCESS;
                  if (w_grant_d) begin
                     r_owner_d   <= 1'b1;
                     mem_address <= d_addr;
                     mem_size    <= d_size;
                     mem_wdata   <= d_wdata;
                     mem_read    <= ~d_we;
                     mem_write   <= d_we;
                     // Only count data grants that actually made a fetch wait
                     if (i_req)
                        r_starve <= (r_starve == c_LIMIT) ? c_LIMIT : r_starve + 4'd1;
                     else
                        r_starve <= 4'd0;
                  end else begin
                     r_owner_d   <= 1'b0;
                     mem_address <= i_addr;
                     mem_size    <= c_WORD_SIZE;
                     mem_wdata   <= '0;
                     mem_read    <= 1'b1;
                     mem_write   <= 1'b0;
                     r_starve    <= 4'd0;
                  end
               end
            end

            ACCESS: begin
               // Hold every mem_* output until the memory accepts the access
               if (mem_ready) begin
                  r_state   <= RESP;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (r_owner_d) begin
                     d_done <= 1'b1;
                     if (!mem_write)
                        d_rdata <= mem_rdata;
                  end else begin
                     i_done  <= 1'b1;
                     i_rdata <= mem_rdata;
                  end
               end
            end

            RESP: begin
               i_done  <= 1'b0;
               d_done  <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A transaction-level
//               model tracks pending requests, starvation history and the
//               expected read-data registers.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mem_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int LIMIT = 4;

   logic          clk;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_done;
   logic [DW-1:0] i_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [2:0]    d_size;
   logic [DW-1:0] d_wdata;
   logic          d_done;
   logic [DW-1:0] d_rdata;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [2:0]    mem_size;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          busy;

   mem_arbiter #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_done     (i_done),
      .i_rdata    (i_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_size     (d_size),
      .d_wdata    (d_wdata),
      .d_done     (d_done),
      .d_rdata    (d_rdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_address(mem_address),
      .mem_size   (mem_size),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit            ip, dp;          // pending instruction / data requests
   logic [AW-1:0] ia;
   logic          dwe;
   logic [AW-1:0] da;
   logic [2:0]    dsz;
   logic [DW-1:0] dwd;
   int            waited;          // data grants in a row while a fetch was pending
   logic [DW-1:0] exp_i_rdata, exp_d_rdata;
   int            n_data_grants, n_inst_grants;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction from IDLE: grant, ACCESS (lat wait cycles), RESP, IDLE
   task automatic do_txn(input int lat);
      bit            win_d;
      logic [DW-1:0] rd;
      logic [AW-1:0] e_addr;
      logic [2:0]    e_size;
      logic          e_rd, e_wr;

      // Fetch gets the grant only when data is absent or the fetch has waited
      // through LIMIT data grants in a row.
      win_d = dp && !(ip && waited >= LIMIT);
      if (win_d) begin
         waited = ip ? waited + 1 : 0;
         n_data_grants++;
      end else begin
         waited = 0;
         n_inst_grants++;
      end
      e_addr = win_d ? da : ia;
      e_size = win_d ? dsz : 3'b010;
      e_rd   = win_d ? !dwe : 1'b1;
      e_wr   = win_d ? dwe : 1'b0;

      i_req = ip; i_addr = ia;
      d_req = dp; d_we = dwe; d_addr = da; d_size = dsz; d_wdata = dwd;
      mem_ready = 1'b0;
      step();
      chk("grant_busy", busy, 1);
      chk("grant_read", mem_read, e_rd);
      chk("grant_write", mem_write, e_wr);
      chk("grant_addr", mem_address, e_addr);
      chk("grant_size", mem_size, e_size);
      if (win_d && dwe) chk("grant_wdata", mem_wdata, dwd);

      // Winner changes its inputs after grant; the latched access must not move
      if (win_d) begin d_addr = $urandom; d_wdata = $urandom; d_size = 3'($urandom); end
      else       i_addr = $urandom;

      for (int k = 0; k < lat; k++) begin
         mem_rdata = $urandom;
         step();
         chk("wait_read", mem_read, e_rd);
         chk("wait_write", mem_write, e_wr);
         chk("wait_addr", mem_address, e_addr);
         chk("wait_size", mem_size, e_size);
         chk("wait_dones", {i_done, d_done}, 0);
      end

      rd = $urandom;
      mem_rdata = rd;
      mem_ready = 1'b1;
      step();
      if (win_d && !dwe) exp_d_rdata = rd;
      if (!win_d)        exp_i_rdata = rd;
      chk("resp_i_done", i_done, !win_d);
      chk("resp_d_done", d_done, win_d);
      chk("resp_rw_idle", {mem_read, mem_write}, 0);
      chk("resp_busy", busy, 1);
      chk("resp_i_rdata", i_rdata, exp_i_rdata);
      chk("resp_d_rdata", d_rdata, exp_d_rdata);

      // Requester drops its request on the edge where done is seen
      mem_ready = 1'b0;
      if (win_d) begin dp = 0; d_req = 1'b0; end
      else       begin ip = 0; i_req = 1'b0; end
      step();
      chk("idle_dones", {i_done, d_done}, 0);
      chk("idle_busy", busy, 0);
      chk("idle_rw", {mem_read, mem_write}, 0);
   endtask

   initial begin
      rst = 1'b1;
      i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_size = '0; d_wdata = '0;
      mem_rdata = '0; mem_ready = 0;
      ip = 0; dp = 0; ia = '0; dwe = 0; da = '0; dsz = '0; dwd = '0;
      waited = 0; exp_i_rdata = '0; exp_d_rdata = '0;
      n_data_grants = 0; n_inst_grants = 0;

      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_rw", {mem_read, mem_write}, 0);
      chk("rst_dones", {i_done, d_done}, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_addr", mem_address, 0);
      rst = 1'b0;

      // No request: stay idle
      step();
      step();
      chk("noreq_busy", busy, 0);
      chk("noreq_rw", {mem_read, mem_write}, 0);

      // Single fetch
      ip = 1; ia = 32'h100;
      do_txn(0);

      // Simultaneous: data write wins, then the fetch
      ip = 1; ia = 32'h200;
      dp = 1; dwe = 1; da = 32'h40; dsz = 3'b000; dwd = 32'hAB;
      do_txn(0);
      chk("both_inst_pending", ip, 1);
      do_txn(0);

      // Starvation: fetch held, data back-to-back
      ip = 1; ia = 32'h300;
      for (int g = 0; g < LIMIT + 1; g++) begin
         dp = 1; dwe = g[0]; da = 32'h1000 + g; dsz = 3'b010; dwd = $urandom;
         do_txn(0);
         if (g < LIMIT) chk("starve_inst_waiting", ip, 1);
      end
      chk("starve_inst_served", ip, 0);
      // Counter cleared: data wins again over a fresh fetch
      ip = 1; ia = 32'h304;
      dp = 1; dwe = 0; da = 32'h2000; dsz = 3'b010;
      do_txn(0);
      chk("after_starve_data_first", dp, 0);
      do_txn(0);

      // Slow memory read
      dp = 1; dwe = 0; da = 32'h80; dsz = 3'b001;
      do_txn(3);

      // Reset in the middle of ACCESS
      dp = 1; dwe = 0; da = 32'h90; dsz = 3'b010;
      d_req = 1; d_we = 0; d_addr = da; d_size = dsz;
      step();
      chk("midrst_pre_read", mem_read, 1);
      rst = 1'b1;
      #1;
      chk("midrst_rw", {mem_read, mem_write}, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rdata", {i_rdata, d_rdata}, 0);
      d_req = 0; dp = 0; ip = 0;
      waited = 0; exp_i_rdata = '0; exp_d_rdata = '0;
      mem_ready = 1'b1;
      step();
      chk("midrst_nodone", {i_done, d_done}, 0);
      rst = 1'b0;
      mem_ready = 1'b0;
      step();
      chk("postrst_nodone", {i_done, d_done}, 0);
      chk("postrst_busy", busy, 0);

      // Randomized traffic
      for (int it = 0; it < 80; it++) begin
         if (!ip && ($urandom_range(0, 1) == 1)) begin ip = 1; ia = $urandom; end
         if (!dp && ($urandom_range(0, 3) != 0)) begin
            dp = 1; dwe = 1'($urandom); da = $urandom; dsz = 3'($urandom); dwd = $urandom;
         end
         if (!ip && !dp) begin ip = 1; ia = $urandom; end
         do_txn(int'($urandom_range(0, 3)));
      end
      chk("grants_seen", (n_data_grants > 10) && (n_inst_grants > 10), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive data grants tolerated while instruction waits (range 1..15).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have i_req  input  1  instruction fetch request; i_addr  input  ADDR_WIDTH  fetch address.
REQ-007 SHALL have i_done  output  1  one-cycle fetch completion; i_rdata  output  DATA_WIDTH  fetched word.
REQ-008 SHALL have d_req  input  1  data request; d_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have d_addr  input  ADDR_WIDTH; d_size  input  3  memory SizeCtr code; d_wdata  input  DATA_WIDTH.
REQ-010 SHALL have d_done  output  1  one-cycle data completion; d_rdata  output  DATA_WIDTH  load result.
REQ-011 SHALL have mem_read, mem_write  output  1 each; mem_address  output  ADDR_WIDTH; mem_size  output  3; mem_wdata  output  DATA_WIDTH.
REQ-012 SHALL have mem_rdata  input  DATA_WIDTH; mem_ready  input  1  memory access complete.
REQ-013 SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP with registered state.
REQ-015 SHALL, in IDLE with any request high, select a winner, latch owner, address, size, we, wdata at the clock edge, and enter ACCESS.
REQ-016 SHALL stay in IDLE with mem_read = mem_write = 0 when no request is high.
REQ-017 SHALL grant data over instruction when both request, except when starve_cnt == STARVE_LIMIT, in which case instruction wins.
REQ-018 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on each data grant made while i_req is high, and clear it on every instruction grant or on a data grant with i_req low.
REQ-019 SHALL, for instruction grants, force latched size 3'b010 and we = 0.
REQ-020 SHALL, in ACCESS, drive mem_address/mem_size/mem_wdata from latched values, mem_read = ~we, mem_write = we.
REQ-021 SHALL remain in ACCESS holding all mem_* outputs stable while mem_ready = 0; no timeout.
REQ-022 SHALL, in ACCESS with mem_ready = 1, capture mem_rdata into the owner's rdata register (reads only) and enter RESP.
REQ-023 SHALL assert mem_write for exactly the ACCESS cycles, so a write with mem_ready = 1 is a single-cycle write.
REQ-024 SHALL, in RESP, pulse the owner's done for exactly one cycle, drive mem_read = mem_write = 0, then enter IDLE.
REQ-025 SHALL give latency with mem_ready = 1: request sampled in IDLE at cycle N, ACCESS N+1, done high N+2, next grant possible at N+3.
REQ-026 SHALL hold i_rdata/d_rdata until the next completed read of the same owner; data writes leave d_rdata unchanged.
REQ-027 SHALL ignore request deassertion or input changes after grant; the latched transaction always completes.
REQ-028 SHALL treat a request still high in IDLE after its done as a new transaction; requesters drop req on the edge at which done is seen.
REQ-029 SHALL forward d_size unchanged and not check alignment; any size code completes with d_done.
REQ-030 SHALL never assert i_done and d_done in the same cycle, nor mem_read and mem_write together.

Reset
REQ-031 SHALL, on rst assertion, asynchronously force state IDLE, starve_cnt 0, and all outputs including i_rdata/d_rdata to 0.
REQ-032 SHALL abort any in-flight transaction on reset with no done pulse; first grant occurs in the first IDLE cycle after rst deasserts.

Verification
REQ-033 SHALL cover: i_req only, i_addr=0x100, mem_rdata=0xDEADBEEF, mem_ready=1 -> mem_read, mem_size=3'b010 one cycle; i_done and i_rdata=0xDEADBEEF two cycles after grant.
REQ-034 SHALL cover: i_req and d_req (d_we=1, d_addr=0x40, d_size=3'b000, d_wdata=0xAB) together -> data granted first, mem_write one cycle, d_done; then fetch granted, i_done.
REQ-035 SHALL cover: i_req held high, d_req reasserted back-to-back, STARVE_LIMIT=4 -> four data grants, fifth grant to instruction, starve_cnt back to 0.
REQ-036 SHALL cover: data read, mem_ready low for 3 cycles -> mem_* outputs stable 3 cycles, d_done one cycle after mem_ready rises, d_rdata = mem_rdata.
REQ-037 SHALL cover: rst asserted mid-ACCESS -> mem_read/mem_write and busy 0 immediately, no done pulse, rdata registers 0.
